code_conv_seq: RTL and testbench

CODE_CONV_SEQ -- requirements
Module: code_conv_seq

---
 rtl/code_conv_seq.sv | 118 +++++++++++
 tb/tb_code_conv_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_seq.sv
// Sequential code converter: binary<->Gray in one cycle, binary->BCD / excess-3 BCD
// by shift-add-3 at one bit per cycle (WIDTH cycles); new requests taken only in IDLE.
module code_conv_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [WIDTH-1:0]      a_in,
    input  logic [1:0]            mode_in,
    input  logic                  valid_in,
    input  logic                  clear_in,
    output logic                  ready_out,
    output logic                  done_out,
    output logic [4*DIGITS-1:0]   y_out
);

    localparam int OUT_W = 4 * DIGITS;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic bit digits_ok(input int w, input int d);
        logic [127:0] p;
        logic [127:0] m;
        p = 128'd1;
        for (int i = 0; i < d; i++) p = p * 128'd10;
        m = (128'd1 << w) - 128'd1;
        return p > m;
    endfunction

    generate
        if (WIDTH < 2 || !digits_ok(WIDTH, DIGITS)) begin : g_param_err
            $error("code_conv_seq: WIDTH must be >= 2 and 10**DIGITS must exceed 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   bin_q;
    logic [OUT_W-1:0]   bcd_q;
    logic [CW-1:0]      cnt_q;

    logic [OUT_W-1:0]   bcd_adj;
    logic [OUT_W-1:0]   bcd_next;
    logic [OUT_W-1:0]   xs3_next;
    logic [WIDTH-1:0]   gray;
    logic [WIDTH-1:0]   gbin;

    assign ready_out = (state == IDLE);

    // bin_q holds the captured operand; in BCD modes it doubles as the shift register.
    always_comb begin
        bcd_adj  = bcd_q;
        xs3_next = '0;
        gbin     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[OUT_W-2:0], bin_q[WIDTH-1]};
        for (int i = 0; i < DIGITS; i++)
            xs3_next[4*i +: 4] = bcd_next[4*i +: 4] + 4'd3;
        gray = bin_q ^ (bin_q >> 1);
        for (int i = 0; i < WIDTH; i++)
            gbin[i] = ^(bin_q >> i);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            y_out    <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in && !clear_in) begin
                        bin_q  <= a_in;
                        mode_q <= mode_in;
                        bcd_q  <= '0;
                        cnt_q  <= '0;
                        state  <= mode_in[1] ? SHIFT : CONV;
                    end
                end
                CONV: begin
                    if (!clear_in) begin
                        y_out    <= mode_q[0] ? OUT_W'(gbin) : OUT_W'(gray);
                        done_out <= 1'b1;
                    end
                    state <= IDLE;
                end
                SHIFT: begin
                    if (clear_in) begin
                        state <= IDLE;
                    end else begin
                        bcd_q <= bcd_next;
                        bin_q <= bin_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                        // Completion uses the just-shifted value so latency is exactly WIDTH.
                        if (cnt_q == CNT_LAST) begin
                            y_out    <= mode_q[0] ? bcd_next : xs3_next;
                            done_out <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_conv_seq.sv
module tb_code_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a = '0;
    logic [1:0]  mode = '0;
    logic        valid = 1'b0;
    logic        clear = 1'b0;
    logic        ready;
    logic        done;
    logic [11:0] y;

    int checks = 0;
    int errors = 0;
    logic [11:0] last_y = '0;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a;
        logic [11:0] y;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    code_conv_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .a_in      (a),
        .mode_in   (mode),
        .valid_in  (valid),
        .clear_in  (clear),
        .ready_out (ready),
        .done_out  (done),
        .y_out     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called between the accept edge and the next one; counts edges until done_out.
    task automatic wait_done(input string nm, input int lat, input logic [11:0] ey);
        int n = 0;
        bit rdy_bad = 0;
        while (done !== 1'b1 && n < 20) begin
            if (ready !== 1'b0) rdy_bad = 1;
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, n, lat);
        check({nm, "_y"}, y, ey);
        check({nm, "_ready_low"}, rdy_bad, 0);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 1'b0);
        check({nm, "_y_hold"}, y, ey);
        last_y = ey;
    endtask

    task automatic run_req(input string nm, input logic [1:0] m, input logic [7:0] v,
                           input logic [11:0] ey, input int lat);
        @(negedge clk);
        check({nm, "_ready"}, ready, 1'b1);
        valid = 1'b1;
        mode  = m;
        a     = v;
        @(negedge clk);
        valid = 1'b0;
        a     = ~v;
        mode  = ~m;
        wait_done(nm, lat, ey);
    endtask

    initial begin
        tbl[0]  = '{2'b00, 8'hB4, 12'h0EE, 1};
        tbl[1]  = '{2'b01, 8'hEE, 12'h0B4, 1};
        tbl[2]  = '{2'b11, 8'd255, 12'h255, 8};
        tbl[3]  = '{2'b11, 8'd0,   12'h000, 8};
        tbl[4]  = '{2'b10, 8'd97,  12'h3CA, 8};
        tbl[5]  = '{2'b10, 8'd0,   12'h333, 8};
        tbl[6]  = '{2'b00, 8'hFF,  12'h080, 1};
        tbl[7]  = '{2'b01, 8'h80,  12'h0FF, 1};
        tbl[8]  = '{2'b11, 8'd128, 12'h128, 8};
        tbl[9]  = '{2'b10, 8'd9,   12'h33C, 8};
        tbl[10] = '{2'b11, 8'd200, 12'h200, 8};
        tbl[11] = '{2'b01, 8'h01,  12'h001, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_y", y, 12'h000);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_req($sformatf("vec%0d", i), tbl[i].mode, tbl[i].a, tbl[i].y, tbl[i].lat);

        // Back-to-back: second request accepted exactly two edges after the first
        @(negedge clk);
        valid = 1'b1; mode = 2'b01; a = 8'hEE;
        @(negedge clk);
        check("b2b_busy", ready, 1'b0);
        mode = 2'b00; a = 8'hB4;
        @(negedge clk);
        check("b2b_first_done", done, 1'b1);
        check("b2b_first_y", y, 12'h0B4);
        check("b2b_ready_again", ready, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        check("b2b_second_busy", ready, 1'b0);
        check("b2b_second_nodone", done, 1'b0);
        @(negedge clk);
        check("b2b_second_done", done, 1'b1);
        check("b2b_second_y", y, 12'h0EE);
        last_y = 12'h0EE;

        // Clear in 4th SHIFT cycle, with valid held during SHIFT (must be dropped)
        @(negedge clk);
        valid = 1'b1; mode = 2'b11; a = 8'd97;
        @(negedge clk);
        mode = 2'b00; a = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("clr_shift_busy", ready, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_shift_ready", ready, 1'b1);
        check("clr_shift_nodone", done, 1'b0);
        check("clr_shift_y", y, last_y);
        begin
            bit seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (done !== 1'b0 || ready !== 1'b1) seen = 1;
            end
            check("clr_shift_no_queue", seen, 0);
        end

        // Clear beats completion in CONV
        @(negedge clk);
        valid = 1'b1; mode = 2'b00; a = 8'h12;
        @(negedge clk);
        valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_conv_nodone", done, 1'b0);
        check("clr_conv_ready", ready, 1'b1);
        check("clr_conv_y", y, last_y);

        // Clear beats completion on the final SHIFT edge
        @(negedge clk);
        valid = 1'b1; mode = 2'b11; a = 8'd42;
        @(negedge clk);
        valid = 1'b0;
        repeat (7) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_last_nodone", done, 1'b0);
        check("clr_last_ready", ready, 1'b1);
        check("clr_last_y", y, last_y);

        // Clear with valid in IDLE: request refused
        @(negedge clk);
        valid = 1'b1; clear = 1'b1; mode = 2'b00; a = 8'h33;
        @(negedge clk);
        valid = 1'b0; clear = 1'b0;
        check("clr_idle_ready", ready, 1'b1);
        @(negedge clk);
        check("clr_idle_nodone", done, 1'b0);
        check("clr_idle_y", y, last_y);

        // Asynchronous reset mid-SHIFT, then immediate new request
        @(negedge clk);
        valid = 1'b1; mode = 2'b11; a = 8'd255;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", ready, 1'b1);
        check("arst_done", done, 1'b0);
        check("arst_y", y, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1; mode = 2'b00; a = 8'hB4;
        @(negedge clk);
        valid = 1'b0;
        wait_done("post_rst", 1, 12'h0EE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
